cordic_iter_engine: RTL

- Iterative, parametrised CORDIC engine computing one micro-rotation per clock, supporting both rotation mode (sine/cosine) and vectoring mode (magnitude/atan2).
- It is the next generation of the existing free-running CORDIC_main. It adds:
  - valid/ready handshakes on input and output,
  - full-circle quadrant pre-rotation,
  - optional gain compensation with output saturation.
- It feeds the phase-correlation datapath, where it converts between phase angles and cartesian values.

---
 rtl/cordic_iter_engine.sv | 217 +++++++++++++++++++++
 1 files changed

// File: rtl/cordic_iter_engine.sv
// cordic_iter_engine
//   Iterative CORDIC engine, one micro-rotation per clock.
//   mode 0 (rotation):  rotates (x_in, y_in) by z_in, yielding cos/sin-style results.
//   mode 1 (vectoring): rotates (x_in, y_in) onto the +x axis, yielding the
//                       magnitude in x_out and atan2(y_in, x_in) in z_out.
//   Angles are 32-bit binary angles: the full circle is 2^32.
//
// Ports
//   clock, reset              rising-edge clock, asynchronous active-high reset
//   in_valid / in_ready       request handshake; in_ready is high only when idle
//   mode, x_in, y_in, z_in    request operands, sampled at the accepting edge
//   out_valid / out_ready     result handshake; results hold while out_ready = 0
//   x_out, y_out              saturated WIDTH-bit results
//   z_out                     residual angle (rotation) or atan2 (vectoring)
//   mode_out                  mode of the result currently presented
module cordic_iter_engine #(
  parameter int WIDTH     = 16,
  parameter int ITER      = 16,
  parameter int GAIN_COMP = 1
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic             mode,
  input  logic [WIDTH-1:0] x_in,
  input  logic [WIDTH-1:0] y_in,
  input  logic [31:0]      z_in,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] x_out,
  output logic [WIDTH-1:0] y_out,
  output logic [31:0]      z_out,
  output logic             mode_out
);

  // Two MSBs of headroom: the CORDIC gain (~1.647) and negation of the most
  // negative input both fit without overflow.
  localparam int XW = WIDTH + 2;
  localparam logic signed [XW+16:0] INV_GAIN = 19899;  // 1/K in Q1.15

  typedef enum logic [1:0] {S_IDLE, S_ITER, S_COMP, S_DONE} state_t;

  state_t               state, state_nxt;
  logic signed [XW-1:0] x_r, y_r, x_nxt, y_nxt;
  logic signed [31:0]   z_r, z_nxt;
  logic [4:0]           cnt, cnt_nxt;
  logic                 mode_r, mode_nxt;

  logic signed [XW-1:0] x_ext, y_ext, xs, ys;
  logic signed [31:0]   atan_i;
  logic                 d_pos;

  function automatic logic signed [31:0] atan_lut(input logic [4:0] idx);
    case (idx)
      5'd0:  return 32'sd536870912;
      5'd1:  return 32'sd316933406;
      5'd2:  return 32'sd167458907;
      5'd3:  return 32'sd85004756;
      5'd4:  return 32'sd42667331;
      5'd5:  return 32'sd21354465;
      5'd6:  return 32'sd10679838;
      5'd7:  return 32'sd5340245;
      5'd8:  return 32'sd2670163;
      5'd9:  return 32'sd1335087;
      5'd10: return 32'sd667544;
      5'd11: return 32'sd333772;
      5'd12: return 32'sd166886;
      5'd13: return 32'sd83443;
      5'd14: return 32'sd41722;
      5'd15: return 32'sd20861;
      5'd16: return 32'sd10430;
      5'd17: return 32'sd5215;
      5'd18: return 32'sd2608;
      5'd19: return 32'sd1304;
      5'd20: return 32'sd652;
      5'd21: return 32'sd326;
      5'd22: return 32'sd163;
      5'd23: return 32'sd81;
      5'd24: return 32'sd41;
      5'd25: return 32'sd20;
      5'd26: return 32'sd10;
      5'd27: return 32'sd5;
      5'd28: return 32'sd3;
      5'd29: return 32'sd1;
      5'd30: return 32'sd1;
      default: return 32'sd0;
    endcase
  endfunction

  // Multiply by 1/K and shift right 15 (floor); |result| < |v| so it fits XW bits.
  function automatic logic signed [XW-1:0] gain_comp(input logic signed [XW-1:0] v);
    logic signed [XW+16:0] p;
    p = (XW+17)'(v) * INV_GAIN;
    return p[XW+14:15];
  endfunction

  // Clamp to the signed WIDTH range; in range when the top XW-WIDTH+1 bits agree.
  function automatic logic [WIDTH-1:0] sat(input logic signed [XW-1:0] v);
    if (v[XW-1:WIDTH-1] == {(XW-WIDTH+1){v[XW-1]}})
      return v[WIDTH-1:0];
    else if (v[XW-1])
      return {1'b1, {(WIDTH-1){1'b0}}};
    else
      return {1'b0, {(WIDTH-1){1'b1}}};
  endfunction

  assign x_ext  = {{2{x_in[WIDTH-1]}}, x_in};
  assign y_ext  = {{2{y_in[WIDTH-1]}}, y_in};
  assign xs     = x_r >>> cnt;
  assign ys     = y_r >>> cnt;
  assign atan_i = atan_lut(cnt);
  // Rotation drives z toward 0; vectoring drives y toward 0.
  assign d_pos  = mode_r ? y_r[XW-1] : ~z_r[31];

  assign in_ready  = (state == S_IDLE);
  assign out_valid = (state == S_DONE);

  always_ff @(posedge clock or posedge reset) begin
    if (reset) state <= S_IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    x_nxt     = x_r;
    y_nxt     = y_r;
    z_nxt     = z_r;
    cnt_nxt   = cnt;
    mode_nxt  = mode_r;
    case (state)
      // Accept: quadrant pre-rotation brings the problem into the +-90 deg
      // convergence range of the micro-rotations.
      S_IDLE: begin
        if (in_valid) begin
          mode_nxt  = mode;
          cnt_nxt   = 5'd0;
          state_nxt = S_ITER;
          if (!mode) begin
            if (z_in[31] ^ z_in[30]) begin
              x_nxt = -x_ext;
              y_nxt = -y_ext;
              z_nxt = {~z_in[31], z_in[30:0]};
            end else begin
              x_nxt = x_ext;
              y_nxt = y_ext;
              z_nxt = z_in;
            end
          end else begin
            if (x_in[WIDTH-1]) begin
              x_nxt = -x_ext;
              y_nxt = -y_ext;
              z_nxt = 32'sh80000000;
            end else begin
              x_nxt = x_ext;
              y_nxt = y_ext;
              z_nxt = 32'sd0;
            end
          end
        end
      end
      // Micro-rotation cnt
      S_ITER: begin
        if (d_pos) begin
          x_nxt = x_r - ys;
          y_nxt = y_r + xs;
          z_nxt = z_r - atan_i;
        end else begin
          x_nxt = x_r + ys;
          y_nxt = y_r - xs;
          z_nxt = z_r + atan_i;
        end
        cnt_nxt = cnt + 5'd1;
        if (cnt == 5'(ITER-1))
          state_nxt = (GAIN_COMP != 0) ? S_COMP : S_DONE;
      end
      // Gain compensation
      S_COMP: begin
        x_nxt     = gain_comp(x_r);
        y_nxt     = gain_comp(y_r);
        state_nxt = S_DONE;
      end
      S_DONE: begin
        if (out_ready) state_nxt = S_IDLE;
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      x_r      <= '0;
      y_r      <= '0;
      z_r      <= '0;
      cnt      <= '0;
      mode_r   <= 1'b0;
      x_out    <= '0;
      y_out    <= '0;
      z_out    <= '0;
      mode_out <= 1'b0;
    end else begin
      x_r    <= x_nxt;
      y_r    <= y_nxt;
      z_r    <= z_nxt;
      cnt    <= cnt_nxt;
      mode_r <= mode_nxt;
      // Result registers load once on entry to DONE and hold until the next result.
      if (state != S_DONE && state_nxt == S_DONE) begin
        x_out    <= sat(x_nxt);
        y_out    <= sat(y_nxt);
        z_out    <= z_nxt;
        mode_out <= mode_r;
      end
    end
  end

endmodule
